// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size encoding (also used by CPU decode),
// FSM state encoding and small helpers for alignment handling.
package lsu_pkg;

  // Access size as encoded in the load/store instruction; 2'd3 is illegal.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // LSU sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int MIN_LATENCY = 1;
  localparam int MAX_LATENCY = 4;

  // Illegal size code or an address not naturally aligned for the size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'd3) ||
           ((size == 2'd1) && lo[0]) ||
           ((size == 2'd2) && (lo != 2'b00));
  endfunction

  // Illegal size code is treated as a word access.
  function automatic size_e norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SZ_W : size_e'(size);
  endfunction

  // Byte offset forced to natural alignment for the given size.
  function automatic logic [1:0] align_off(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_B:    return lo;
      SZ_H:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mc_if.sv
// Core request/response and data-memory port bundle of the LSU.
// slave = LSU side, master = core + memory side.
interface lsu_mc_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr_data;
  logic [31:0] data_out_data;
  logic [31:0] data_in_data;
  logic        en_data;
  logic [3:0]  we_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, data_in_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           addr_data, data_out_data, en_data, we_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, data_in_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           addr_data, data_out_data, en_data, we_data
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes and lane replication for the
// incoming request, and load lane extraction plus sign/zero extension for
// the latched access.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_data,
  input  size_e       ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = ld_rdata[8*gi +: 8];
  end

  assign byte_val = lane[ld_off];
  assign half_val = ld_off[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  // Store: strobe the addressed lanes and replicate data so every lane carries it.
  always_comb begin
    st_strb = 4'b1111;
    st_data = st_wdata;
    case (st_size)
      SZ_B: begin
        st_strb = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_strb = 4'b0011 << {st_off[1], 1'b0};
        st_data = {2{st_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = st_wdata;
      end
    endcase
  end

  // Load: pick the little-endian lane(s) and extend to 32 bits.
  always_comb begin
    ld_data = ld_rdata;
    case (ld_size)
      SZ_B:    ld_data = ld_unsigned ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
      SZ_H:    ld_data = ld_unsigned ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: one access in flight, IDLE -> ACCESS ->
// (WAIT for loads) -> RESP. Optional macro LSU_MISALIGN_TRAP_EN turns
// misaligned/illegal accesses into an immediate error response; without it
// such accesses are silently aligned and size 3 is treated as word.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int WORD_ADDR   = 1
) (
  input  logic     aclk,
  input  logic     aresetn,
  lsu_mc_if.slave  bus
);

  if (MEM_LATENCY < MIN_LATENCY || MEM_LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("lsu_mc: MEM_LATENCY must be in 1..4");
  end

  state_e      state_reg;
  logic [1:0]  cnt_reg;
  logic        lat_we_reg;
  size_e       lat_size_reg;
  logic [1:0]  lat_off_reg;
  logic        lat_unsigned_reg;
  logic        en_reg;
  logic [3:0]  we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  size_e       in_size;
  logic [1:0]  in_off;
  logic        in_bad;
  logic [31:0] in_mem_addr;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign in_size = norm_size(bus.req_size);
  assign in_off  = align_off(in_size, bus.req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
  assign in_bad  = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign in_bad  = 1'b0;
`endif
  assign in_mem_addr = (WORD_ADDR != 0) ? {2'b00, bus.req_addr[31:2]}
                                        : {bus.req_addr[31:2], 2'b00};

  lsu_align u_align (
    .st_size     (in_size),
    .st_off      (in_off),
    .st_wdata    (bus.req_wdata),
    .st_strb     (st_strb),
    .st_data     (st_data),
    .ld_size     (lat_size_reg),
    .ld_off      (lat_off_reg),
    .ld_unsigned (lat_unsigned_reg),
    .ld_rdata    (bus.data_in_data),
    .ld_data     (ld_data)
  );

  // Sequencer with registered memory-port and response outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg        <= IDLE;
      cnt_reg          <= 2'd0;
      lat_we_reg       <= 1'b0;
      lat_size_reg     <= SZ_B;
      lat_off_reg      <= 2'b00;
      lat_unsigned_reg <= 1'b0;
      en_reg           <= 1'b0;
      we_reg           <= 4'b0000;
      addr_reg         <= 32'd0;
      wdata_reg        <= 32'd0;
      resp_valid_reg   <= 1'b0;
      resp_rdata_reg   <= 32'd0;
      resp_err_reg     <= 1'b0;
    end else begin
      en_reg         <= 1'b0;
      we_reg         <= 4'b0000;
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            lat_we_reg       <= bus.req_we;
            lat_size_reg     <= in_size;
            lat_off_reg      <= in_off;
            lat_unsigned_reg <= bus.req_unsigned;
            if (in_bad) begin
              // Trapped access never reaches memory; respond next cycle.
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'd0;
            end else begin
              state_reg <= ACCESS;
              en_reg    <= 1'b1;
              we_reg    <= bus.req_we ? st_strb : 4'b0000;
              addr_reg  <= in_mem_addr;
              wdata_reg <= st_data;
            end
          end
        end
        ACCESS: begin
          if (lat_we_reg) begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'd0;
          end else begin
            state_reg <= WAIT;
            cnt_reg   <= 2'(MEM_LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt_reg == 2'd0) begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= ld_data;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = (state_reg == IDLE);
  assign bus.en_data       = en_reg;
  assign bus.we_data       = we_reg;
  assign bus.addr_data     = addr_reg;
  assign bus.data_out_data = wdata_reg;
  assign bus.resp_valid    = resp_valid_reg;
  assign bus.resp_rdata    = resp_rdata_reg;
  assign bus.resp_err      = resp_err_reg;

endmodule

// File: doc/lsu_mc.md
LSU_MC -- requirements
Module: lsu_mc

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, meaning data-port read latency in cycles from en_data high to data_in_data valid; legal range 1..4, any other value is an elaboration error.
REQ-002 SHALL have parameter WORD_ADDR, default 1, meaning 1 drives word address {2'b00, addr[31:2]} and 0 drives byte address with addr[1:0] forced to 0.
REQ-003 SHALL have ports, one per line:
  aclk  in  1  clock; reset aresetn, synchronous, active-low; clock aclk
  aresetn  in  1  synchronous active-low reset
  req_valid  in  1  core issues access
  req_ready  out  1  LSU can accept
  req_we  in  1  1 = store, 0 = load
  req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
  req_unsigned  in  1  load zero-extends (LBU/LHU)
  req_addr  in  32  byte address
  req_wdata  in  32  store data, LSBs significant
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  32  extended load data; 0 for stores
  resp_err  out  1  misaligned or illegal access
  addr_data  out  32  memory address
  data_out_data  out  32  memory write data
  data_in_data  in  32  memory read data
  en_data  out  1  memory enable
  we_data  out  4  byte write strobes, bit i = bits [8i+7:8i]

Function
REQ-004 SHALL implement FSM IDLE -> ACCESS -> (WAIT) -> RESP -> IDLE.
REQ-005 SHALL assert req_ready only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1, and all req_* are latched then.
REQ-006 SHALL, for a request accepted at the end of cycle T, assert en_data for exactly cycle T+1 (ACCESS) with addr_data, we_data, data_out_data valid in that cycle.
REQ-007 SHALL hold we_data = 0 for loads; stores SHALL use byte 4'b0001<<addr[1:0], half 4'b0011<<{addr[1],1'b0}, word 4'b1111.
REQ-008 SHALL replicate the store byte in all four lanes for byte stores, the halfword in both halves for half stores, and pass the full word for word stores.
REQ-009 SHALL, for a store, pulse resp_valid in cycle T+2 with resp_rdata = 0.
REQ-010 SHALL, for a load, count MEM_LATENCY cycles in WAIT, sample data_in_data on the edge ending cycle T+1+MEM_LATENCY, and pulse resp_valid in cycle T+2+MEM_LATENCY.
REQ-011 SHALL extract load lanes little-endian by addr[1:0] (half by addr[1]), sign-extend when req_unsigned = 0 and zero-extend when 1; for word loads req_unsigned is ignored.
REQ-012 SHALL hold resp_rdata and resp_err stable until the next resp_valid; resp_valid has no backpressure.
REQ-013 SHALL keep en_data = 0 and we_data = 0 outside ACCESS, and hold addr_data and data_out_data at their last driven values.
REQ-014 SHALL never accept a new request before RESP completes, so back-to-back throughput is one access per 3 cycles for stores and 3+MEM_LATENCY cycles for loads.

Reset
REQ-015 SHALL, while aresetn = 0 at a rising aclk edge, go to IDLE and clear resp_valid, resp_err, resp_rdata, en_data, we_data, addr_data, data_out_data and the latency counter.
REQ-016 SHALL, on reset mid-access (any state), abort with no resp_valid pulse; req_ready = 1 in the first cycle after reset release.

Configuration
REQ-017 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat half with addr[0] = 1, word with addr[1:0] != 0, or req_size = 3 as an error: no en_data, go IDLE -> RESP, resp_valid and resp_err = 1 in cycle T+1, and resp_rdata = 0.
REQ-018 SHALL, without LSU_MISALIGN_TRAP_EN, force the offending low address bits to natural alignment, treat size 3 as word, and tie resp_err to 0.

Structure
REQ-019 SHALL place the size encoding enum (SZ_B, SZ_H, SZ_W) and the FSM state enum in package lsu_pkg, shared with the CPU decode.
REQ-020 SHALL implement strobe generation, store replication and load extraction/extension in one combinational sub-module lsu_align.

Verification
REQ-021 SB addr 0x0000_0103, wdata 0x0000_00A5 -> cycle T+1: en_data = 1, we_data = 4'b1000, data_out_data = 0xA5A5A5A5, addr_data = 0x40 (WORD_ADDR = 1); resp_valid in T+2.
REQ-022 LB addr 0x102 with memory word 0x1280_3456 and MEM_LATENCY = 3 -> resp_valid in T+5, resp_rdata = 0xFFFF_FF80; repeated as LBU -> 0x0000_0080.
REQ-023 LH addr 0x202 with memory word 0x8001_7FFF -> resp_rdata = 0xFFFF_8001; SW addr 0x204, data 0xDEAD_BEEF -> we_data = 4'b1111.
REQ-024 With the macro defined, LW addr 0x301 -> en_data never high, resp_valid and resp_err = 1 in T+1; without the macro -> access at word 0x300, resp_err = 0.
REQ-025 Reset asserted in a WAIT cycle of a load -> no resp_valid, all outputs 0 next cycle; a new SW after release completes normally.
